divisor_seq: RTL and testbench

Sequential unsigned restoring divider with its own control unit and datapath. It is the inverse companion of the shift-add multiplier and uses the same level-sensitive start/done handshake. It computes one quotient bit every two cycles and holds the result until the requester drops start.

---
 rtl/divisor_seq.sv | 145 ++++++++++++++
 tb/tb_divisor_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/divisor_seq.sv
// rtl/divisor_seq.sv - sequential unsigned restoring divider with start/done handshake
//
// Computes quotient = dividend / divisor and remainder = dividend % divisor,
// one quotient bit per SHIFT/SUB pair. Results are held in DONE until start
// is released. A zero divisor yields quotient = all ones, remainder =
// dividend and div_zero = 1.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      level-held request; sampled in WAIT (capture) and in DONE (release)
//   dividend   N-bit unsigned dividend, sampled at the capture edge only
//   divisor    N-bit unsigned divisor, sampled at the capture edge only
//   quotient   N-bit quotient, valid while done = 1
//   remainder  N-bit remainder, valid while done = 1
//   done       result valid (state DONE)
//   busy       operation in progress (states LOAD, SHIFT, SUB)
//   div_zero   last operation had a zero divisor, valid while done = 1

module divisor_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N:0]    a_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  b_reg;
  logic [CW-1:0] cnt;
  logic          dz_reg;
  logic          b_is_zero;
  logic          a_ge_b;

  assign b_is_zero = (b_reg == '0);
  // Compare in N+1 bits: after a shift the partial remainder can exceed 2^N-1.
  assign a_ge_b    = (a_reg >= {1'b0, b_reg});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_WAIT;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      S_WAIT: begin
        state_next = start ? S_LOAD : S_WAIT;
      end
      S_LOAD: begin
        busy       = 1'b1;
        state_next = b_is_zero ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        state_next = S_SUB;
      end
      S_SUB: begin
        busy       = 1'b1;
        // cnt was decremented in the preceding SHIFT, so 0 marks the last bit.
        state_next = (cnt == '0) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = start ? S_DONE : S_WAIT;
      end
      default: begin
        state_next = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      q_reg  <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      dz_reg <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (start) begin
            q_reg  <= dividend;
            b_reg  <= divisor;
            a_reg  <= '0;
            dz_reg <= 1'b0;
          end
        end
        S_LOAD: begin
          cnt <= CW'(N);
          if (b_is_zero) begin
            // Remainder takes the untouched dividend still sitting in Q.
            dz_reg <= 1'b1;
            q_reg  <= '1;
            a_reg  <= {1'b0, q_reg};
          end
        end
        S_SHIFT: begin
          // A < B before the shift, so A[N] is always 0 and is safely dropped.
          {a_reg, q_reg} <= {a_reg[N-1:0], q_reg, 1'b0};
          cnt            <= cnt - CW'(1);
        end
        S_SUB: begin
          if (a_ge_b) begin
            a_reg    <= a_reg - {1'b0, b_reg};
            q_reg[0] <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient  = q_reg;
  assign remainder = a_reg[N-1:0];
  assign div_zero  = dz_reg;

endmodule

// File: tb/tb_divisor_seq.sv
// tb/tb_divisor_seq.sv - scoreboard testbench for divisor_seq

module tb_divisor_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];

  divisor_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_quotient"}, 32'(quotient), 0);
    check({tag, "_remainder"}, 32'(remainder), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_div_zero"}, 32'(div_zero), 0);
  endtask

  // Drive one division, wait for done (bounded), compare against the
  // scoreboard, then exercise the release side of the handshake.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input int hold, input bit drop_mid, input bit scramble);
    exp_t e;
    exp_t got_e;
    int   cyc;
    int   bcnt;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.dz = (b == 0);
    e.q  = (b == 0) ? {N{1'b1}} : N'(a / b);
    e.r  = (b == 0) ? a : N'(a % b);
    sb.push_back(e);
    cyc  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (scramble) begin
        dividend = N'($urandom);
        divisor  = N'($urandom);
      end
      if (drop_mid && cyc == 4) start = 1'b0;
    end while (!done && cyc < 60);
    check("done_seen", 32'(done), 1);
    check("latency", 32'(cyc - 1), (b == 0) ? 1 : 2 * N + 1);
    check("busy_cycles", 32'(bcnt), (b == 0) ? 1 : 2 * N + 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      got_e = sb.pop_front();
      check("quotient", 32'(quotient), 32'(got_e.q));
      check("remainder", 32'(remainder), 32'(got_e.r));
      check("div_zero", 32'(div_zero), 32'(got_e.dz));
    end
    if (drop_mid) begin
      @(negedge clk);
      check("pulse_done_low", 32'(done), 0);
      check("pulse_busy_low", 32'(busy), 0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_done", 32'(done), 1);
        check("hold_quotient", 32'(quotient), 32'(e.q));
        check("hold_remainder", 32'(remainder), 32'(e.r));
        check("hold_div_zero", 32'(div_zero), 32'(e.dz));
      end
      start = 1'b0;
      @(negedge clk);
      check("release_done", 32'(done), 0);
      check("release_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(8'd100, 8'd7,   5, 1'b0, 1'b0);
    run_op(8'd255, 8'd1,   0, 1'b0, 1'b0);
    run_op(8'd255, 8'd255, 0, 1'b0, 1'b0);
    run_op(8'd5,   8'd9,   0, 1'b0, 1'b0);
    run_op(8'd0,   8'd3,   0, 1'b0, 1'b0);
    run_op(8'd200, 8'd0,   2, 1'b0, 1'b0);
    run_op(8'd9,   8'd4,   0, 1'b0, 1'b0);
    run_op(8'd100, 8'd7,   0, 1'b1, 1'b0);
    run_op(8'd100, 8'd7,   0, 1'b0, 1'b1);
    run_op(8'd255, 8'd128, 0, 1'b0, 1'b0);
    run_op(8'd1,   8'd255, 0, 1'b0, 1'b0);
    run_op(8'd0,   8'd0,   0, 1'b0, 1'b0);
    run_op(8'd128, 8'd2,   0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_op(N'($urandom), (i % 17 == 0) ? N'(0) : N'($urandom), 0, 1'b0, 1'b0);
    end

    // Abort during SUB of iteration 3 (after edge e0+6).
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    repeat (7) @(negedge clk);
    check("abort_busy_before", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    start = 1'b0;
    @(negedge clk);
    check_zero_outputs("abort_held");
    rst = 1'b0;
    run_op(8'd77, 8'd6, 0, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
